// File: rtl/binary_divider_seq.sv
// rtl/binary_divider_seq.sv - sequential unsigned restoring divider, one quotient bit per clock
module binary_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  // dq starts as the dividend and fills with quotient bits from the LSB as it shifts
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             dz;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dq_nxt;

  always_comb begin
    accept = start && (state != CALC);
    last   = (cnt == CNT_LAST);
    dz     = (divisor == '0);
  end

  // The restored remainder is always below the divisor, so only the shifted trial needs WIDTH+1 bits.
  // A clear borrow bit in the subtraction means trial >= divisor.
  always_comb begin
    trial   = {rem, dq[WIDTH-1]};
    diff    = trial - {1'b0, dvs};
    qbit    = ~diff[WIDTH];
    rem_nxt = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    dq_nxt  = {dq[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = dz ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = dz ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq          <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (dz) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        dq  <= dividend;
        dvs <= divisor;
        rem <= '0;
        cnt <= '0;
      end
    end else if (state == CALC) begin
      dq  <= dq_nxt;
      rem <= rem_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient    <= dq_nxt;
        remainder   <= rem_nxt;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_binary_divider_seq.sv
// tb/tb_binary_divider_seq.sv - self-checking bench for binary_divider_seq
module tb_binary_divider_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  binary_divider_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: results from / and %, timing as a countdown of remaining CALC cycles
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic         m_dz = 1'b0;
  logic [W-1:0] p_q = '0;
  logic [W-1:0] p_r = '0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dz   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_q    = p_q;
          m_r    = p_r;
          m_dz   = 1'b0;
        end
      end else if (start) begin
        m_a = dividend;
        m_b = divisor;
        if (divisor == '0) begin
          m_done = 1'b1;
          m_q    = '1;
          m_r    = dividend;
          m_dz   = 1'b1;
        end else begin
          m_left = W;
          p_q    = dividend / divisor;
          p_r    = dividend % divisor;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("quotient", 32'(quotient), 32'(m_q));
      chk("remainder", 32'(remainder), 32'(m_r));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_dz));
      chk("busy_and_done", 32'(busy && done), 32'(0));
      if (done && !div_by_zero) begin
        chk("inv_sum", 32'(quotient) * 32'(m_b) + 32'(remainder), 32'(m_a));
        chk("inv_rem_lt_div", 32'(remainder < m_b), 32'(1));
      end
    end
  end

  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Called #1 after the accepting edge (n=1); counts edges until done is seen
  task automatic wait_done(input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                           input int elat, input string nm);
    int n = 1;
    while (!done && n <= 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " done_seen"}, 32'(done), 32'(1));
    chk({nm, " latency"}, 32'(n), 32'(elat));
    chk({nm, " q"}, 32'(quotient), 32'(eq));
    chk({nm, " r"}, 32'(remainder), 32'(er));
    chk({nm, " dz"}, 32'(div_by_zero), 32'(edz));
    chk({nm, " model_q"}, 32'(m_q), 32'(eq));
    chk({nm, " model_r"}, 32'(m_r), 32'(er));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset q", 32'(quotient), 32'(0));
    chk("reset r", 32'(remainder), 32'(0));
    chk("reset dz", 32'(div_by_zero), 32'(0));
    rst_n = 1'b1;

    pulse_start(4'd13, 4'd3);  wait_done(4'd4, 4'd1, 1'b0, 5, "13/3");
    pulse_start(4'd15, 4'd1);  wait_done(4'd15, 4'd0, 1'b0, 5, "15/1");
    pulse_start(4'd5, 4'd7);   wait_done(4'd0, 4'd5, 1'b0, 5, "5/7");
    pulse_start(4'd0, 4'd9);   wait_done(4'd0, 4'd0, 1'b0, 5, "0/9");
    pulse_start(4'd15, 4'd15); wait_done(4'd1, 4'd0, 1'b0, 5, "15/15");
    pulse_start(4'd9, 4'd0);   wait_done(4'd15, 4'd9, 1'b1, 1, "9/0");
    pulse_start(4'd8, 4'd2);   wait_done(4'd4, 4'd0, 1'b0, 5, "8/2");

    // start during CALC is dropped; the accepting edge of 12/5 is E0, the stray pulse lands on E2
    pulse_start(4'd12, 4'd5);
    @(negedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd7;
    divisor  = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignored start busy", 32'(busy), 32'(1));
    wait_done(4'd2, 4'd2, 1'b0, 3, "12/5");

    // start raised inside the DONE cycle begins the next division with no idle cycle
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b busy", 32'(busy), 32'(1));
    wait_done(4'd3, 4'd2, 1'b0, 5, "14/4");

    pulse_start(4'd11, 4'd3);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 32'(0));
    chk("midreset done", 32'(done), 32'(0));
    chk("midreset q", 32'(quotient), 32'(0));
    chk("midreset r", 32'(remainder), 32'(0));
    chk("midreset dz", 32'(div_by_zero), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("no done after reset", 32'(done), 32'(0));
    end
    pulse_start(4'd11, 4'd3);  wait_done(4'd3, 4'd2, 1'b0, 5, "11/3");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        pulse_start(W'(a), W'(b));
        if (b == 0) begin
          wait_done(4'd15, W'(a), 1'b1, 1, "exh");
        end else begin
          wait_done(W'(a / b), W'(a % b), 1'b0, 5, "exh");
        end
      end
    end

    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
